// File: rtl/nec_uart_pkg.sv
`default_nettype none
// ============================================================================
// nec_uart_pkg : shared types and constants for the NEC-to-UART event path
// Revision     : 1.0
// ============================================================================
package nec_uart_pkg;

  localparam logic [7:0] HDR_FRAME  = 8'h55;
  localparam logic [7:0] HDR_REPEAT = 8'h52;

  typedef struct packed {
    logic       rpt;
    logic [7:0] addr;
    logic [7:0] cmd;
  } nec_evt_t;

  typedef enum logic [1:0] {IDLE, HDR, ADDR, CMD} tx_state_e;

  function automatic logic [7:0] hdr_byte(input logic rpt);
    return rpt ? HDR_REPEAT : HDR_FRAME;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nec_evt_fifo.sv
`default_nettype none
// ============================================================================
// nec_evt_fifo : synchronous event FIFO; full is judged before any same-cycle pop
// Revision     : 1.0
// ============================================================================
module nec_evt_fifo
  import nec_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  nec_evt_t din,
  output nec_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  nec_evt_t    mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/nec_uart_ctrl.sv
`default_nettype none
// ============================================================================
// nec_uart_ctrl : validates NEC frames/repeats, queues events, sends 3-byte packets
// Revision      : 1.0
// ============================================================================
module nec_uart_ctrl
  import nec_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REPEAT_DIV = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] frame_in,
  input  logic        frame_en,
  input  logic        repeat_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_err,
  output logic [7:0]  drop_cnt
);

  localparam logic [7:0] RPT_DIV = 8'(REPEAT_DIV);

  logic       last_ok;
  logic [7:0] last_addr;
  logic [7:0] last_cmd;
  logic [7:0] rpt_cnt;
  logic [7:0] rpt_next;
  logic       frame_ok;
  logic       rpt_live;
  logic       rpt_hit;
  logic       push_req;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  nec_evt_t   push_evt;
  nec_evt_t   fifo_dout;
  nec_evt_t   pkt;
  tx_state_e  state;
  logic       xfer;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic       unused_naddr;

  // The inverted address byte is deliberately ignored so extended NEC passes.
  assign unused_naddr = ^frame_in[23:16];

  assign frame_ok  = frame_en && (frame_in[15:8] == ~frame_in[7:0]);
  assign rpt_live  = repeat_en && !frame_en && last_ok;
  assign rpt_next  = rpt_cnt + 8'd1;
  assign rpt_hit   = rpt_live && (rpt_next == RPT_DIV);
  assign push_req  = frame_ok || rpt_hit;
  assign fifo_push = push_req && !fifo_full;
  assign push_evt  = frame_ok ? '{rpt: 1'b0, addr: frame_in[31:24], cmd: frame_in[15:8]}
                              : '{rpt: 1'b1, addr: last_addr, cmd: last_cmd};

  assign drop_inc = {1'b0, push_req && fifo_full}
                  + {1'b0, repeat_en && frame_en}
                  + {1'b0, repeat_en && !frame_en && !last_ok};
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  nec_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_evt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_ok   <= 1'b0;
      last_addr <= 8'h00;
      last_cmd  <= 8'h00;
      rpt_cnt   <= 8'h00;
      frame_err <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      frame_err <= frame_en && !frame_ok;
      drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (frame_ok) begin
        last_ok   <= 1'b1;
        last_addr <= frame_in[31:24];
        last_cmd  <= frame_in[15:8];
        rpt_cnt   <= 8'h00;
      end else if (rpt_live) begin
        rpt_cnt   <= rpt_hit ? 8'h00 : rpt_next;
      end
    end
  end

  assign xfer = tx_valid && tx_ready;

  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      IDLE:    fifo_pop = !fifo_empty;
      CMD:     fifo_pop = xfer && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // tx_data is loaded one byte ahead so the output stays registered and stable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      pkt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            pkt      <= fifo_dout;
            tx_data  <= hdr_byte(fifo_dout.rpt);
            tx_valid <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            tx_data <= pkt.addr;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (xfer) begin
            tx_data <= pkt.cmd;
            state   <= CMD;
          end
        end
        CMD: begin
          if (xfer) begin
            if (fifo_pop) begin
              pkt     <= fifo_dout;
              tx_data <= hdr_byte(fifo_dout.rpt);
              state   <= HDR;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nec_uart_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nec_uart_ctrl : directed + randomized bench against an event-level model
// Revision         : 1.0
// ============================================================================
module tb_nec_uart_ctrl;

  localparam int DEPTH = 4;
  localparam int RDIV  = 3;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] frame_in  = 32'h0;
  logic        frame_en  = 1'b0;
  logic        repeat_en = 1'b0;
  logic        tx_ready  = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        frame_err;
  logic [7:0]  drop_cnt;

  always #10 sys_clk = ~sys_clk;

  nec_uart_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .REPEAT_DIV (RDIV)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .frame_in  (frame_in),
    .frame_en  (frame_en),
    .repeat_en (repeat_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected byte stream plus context, counters and error flag.
  logic [7:0] exp_q[$];
  bit         m_ok;
  logic [7:0] m_addr, m_cmd;
  int         m_rc, m_drop, m_inc;
  bit         m_ferr;

  bit         pv, pr;
  logic [7:0] pd;
  int         bi, rpt_seen;
  logic       s_valid, s_ferr;
  logic [7:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] c);
    return {a, ~a, c, ~c};
  endfunction

  // Capacity: one packet held by the transmitter plus DEPTH queued events.
  task automatic model_push(input bit rpt, input logic [7:0] a, input logic [7:0] c);
    if ((exp_q.size() + 2) / 3 >= DEPTH + 1) m_inc++;
    else begin
      exp_q.push_back(rpt ? 8'h52 : 8'h55);
      exp_q.push_back(a);
      exp_q.push_back(c);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ok = 0; m_rc = 0; m_drop = 0; m_ferr = 0;
    pv = 0; bi = 0;
  endtask

  task automatic step(input logic fe, input logic [31:0] fi, input logic re, input logic rdy);
    frame_en = fe; frame_in = fi; repeat_en = re; tx_ready = rdy;
    @(negedge sys_clk);
    s_valid = tx_valid; s_data = tx_data; s_ferr = frame_err;
    if (pv && !pr) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, pd});
    end
    if (tx_valid && rdy) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_byte observed=0x%0h expected=none", tx_data);
      end
      if (exp_q.size() != 0) begin
        if (bi == 0 && tx_data == 8'h52) rpt_seen++;
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      bi = (bi + 1) % 3;
    end
    pv = tx_valid; pr = rdy; pd = tx_data;
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    @(posedge sys_clk);
    m_inc = 0; m_ferr = 0;
    if (sys_rst_n) begin
      if (fe) begin
        if (fi[15:8] == ~fi[7:0]) begin
          m_ok = 1; m_addr = fi[31:24]; m_cmd = fi[15:8]; m_rc = 0;
          model_push(0, m_addr, m_cmd);
        end else m_ferr = 1;
        if (re) m_inc++;
      end else if (re) begin
        if (!m_ok) m_inc++;
        else begin
          m_rc++;
          if (m_rc == RDIV) begin
            m_rc = 0;
            model_push(1, m_addr, m_cmd);
          end
        end
      end
      m_drop = (m_drop + m_inc > 255) ? 255 : m_drop + m_inc;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && (exp_q.size() != 0 || tx_valid); i++) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] a, c;
    int r0, kind;
    model_reset();
    rpt_seen = 0;

    #35;
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Orphan repeat straight out of reset
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("orphan_drop", {24'd0, drop_cnt}, 1);

    // Single frame latency and byte order
    step(1, 32'h00FFAA55, 0, 1);
    step(0, 0, 0, 1);
    chk("lat_n1_valid", {31'd0, s_valid}, 0);
    step(0, 0, 0, 1);
    chk("lat_hdr_valid", {31'd0, s_valid}, 1);
    chk("lat_hdr", {24'd0, s_data}, 32'h55);
    step(0, 0, 0, 1);
    chk("lat_addr", {24'd0, s_data}, 32'h00);
    step(0, 0, 0, 1);
    chk("lat_cmd", {24'd0, s_data}, 32'hAA);
    drain();

    // Six repeats throttled by three
    r0 = rpt_seen;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
    end
    drain();
    chk("rpt_pkts", rpt_seen - r0, 2);
    chk("rpt_drop", {24'd0, drop_cnt}, 1);

    // Bad cmd check
    step(1, 32'h00FFAA54, 0, 1);
    step(0, 0, 0, 1);
    chk("ferr_pulse", {31'd0, s_ferr}, 1);
    step(0, 0, 0, 1);
    chk("ferr_once", {31'd0, s_ferr}, 0);
    drain();

    // Frame and repeat together
    r0 = rpt_seen;
    step(1, 32'h12ED34CB, 1, 1);
    drain();
    chk("simul_drop", {24'd0, drop_cnt}, 2);
    chk("simul_no_rpt", rpt_seen - r0, 0);

    // Backpressure with overflow
    for (int i = 0; i < 6; i++) begin
      step(1, mk_frame(8'(i + 1), 8'(8'h10 + i)), 0, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("ovf_drop", {24'd0, drop_cnt}, 3);
    chk("ovf_queued", exp_q.size(), 15);
    drain();

    // Random events against random ready
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom); c = 8'($urandom);
      if (exp_q.size() <= 6 && $urandom_range(0, 3) == 0) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: step(1, mk_frame(a, c), 0, $urandom_range(0, 3) != 0);
          1: step(1, mk_frame(a, c) ^ (32'd1 << $urandom_range(0, 7)), 0, $urandom_range(0, 3) != 0);
          2: step(0, 0, 1, $urandom_range(0, 3) != 0);
          default: step(1, mk_frame(a, c), 1, $urandom_range(0, 3) != 0);
        endcase
      end else step(0, 0, 0, $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset during the address byte
    step(1, mk_frame(8'hC3, 8'h5A), 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("mid_addr", {24'd0, s_data}, 32'hC3);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, tx_valid}, 0);
    chk("mid_rst_data", {24'd0, tx_data}, 0);
    chk("mid_rst_drop", {24'd0, drop_cnt}, 0);
    model_reset();
    @(posedge sys_clk); #1;
    step(0, 0, 0, 1);
    sys_rst_n = 1'b1;
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("post_rst_drop", {24'd0, drop_cnt}, 1);
    drain();

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("drop_sat", {24'd0, drop_cnt}, 255);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nec_uart_ctrl.md
# nec_uart_ctrl

Event scheduler between the NEC IR decoder and the UART transmitter. It takes decoded frame and repeat-code pulses from `nec` and validates the command byte. Accepted events are queued in a small FIFO, and each one is serialised into a fixed 3-byte packet over a valid/ready byte interface to the UART TX. It owns repeat throttling, overflow accounting and the last-frame context that repeat codes refer to.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event queue depth; power of two, 2..16.
- `REPEAT_DIV`, 1: forward one repeat code out of every `REPEAT_DIV`; legal range 1..255.

Ports:
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `frame_in`  in  32  decoded frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- `frame_en`  in  1  one-cycle pulse; `frame_in` is valid in the same cycle.
- `repeat_en`  in  1  one-cycle pulse marking a received repeat code.
- `tx_data`  out  8  byte to the UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX accepts the byte; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse when a frame fails the cmd check.
- `drop_cnt`  out  8  saturating count of events lost to a full FIFO or to a repeat with no context.

## Operation
- **Frame check:** on `frame_en`, the frame is valid iff `frame_in[15:8] == ~frame_in[7:0]`. The address is not checked, so extended NEC is allowed.
- **Valid frame:**
  - Load `last_addr`/`last_cmd` and set `last_ok`. This happens even when the FIFO is full.
  - Clear the repeat counter.
  - Push {rpt=0, addr, cmd}.
- **Invalid frame:** pulse `frame_err` next cycle. Nothing is pushed and context is unchanged.
- **Repeat:**
  - If `!last_ok`: drop and increment `drop_cnt`.
  - Otherwise increment the repeat counter. When it equals `REPEAT_DIV`, clear it and push {rpt=1, last_addr, last_cmd}.
  - Throttled repeats are not counted as drops.
- **Simultaneous `frame_en` and `repeat_en`:** the frame is processed. The repeat is discarded and `drop_cnt` is incremented.
- **FIFO full:** fullness is evaluated before any same-cycle pop. A push into a full FIFO is rejected, increments `drop_cnt`, and leaves the FIFO contents unchanged. `drop_cnt` saturates at 255.
- **Packet per event:** header, addr, cmd. The header is 0x55 for a frame and 0x52 for a repeat.
- **FSM states:** IDLE, HDR, ADDR, CMD.
  - IDLE: if the FIFO is not empty, pop into the packet register and go to HDR.
  - HDR → ADDR → CMD: advance on each transfer.
  - CMD: on transfer, if the FIFO is not empty, pop and go to HDR (back-to-back packets). Otherwise go to IDLE.
- **Output hold:** `tx_valid` is high in HDR, ADDR and CMD, and low in IDLE. `tx_data` is driven from the registered packet and stays stable while `tx_valid && !tx_ready`. `tx_valid` never drops without a transfer.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0x00, `frame_err`=0, `drop_cnt`=0, `last_ok`=0, repeat counter 0, FIFO empty, FSM in IDLE.
- **Latency:** `frame_en` high in cycle N with the FIFO empty and the FSM in IDLE:
  - push at the end of N;
  - pop at the end of N+1;
  - `tx_valid`=1 with header from cycle N+2.
- **Throughput:** with `tx_ready` held high, one byte per cycle. Packets are back-to-back with no idle cycle between them.
- **`frame_err` timing:** the pulse is high in cycle N+1 for exactly one cycle.
- **Reset mid-packet:** `tx_valid` falls immediately (asynchronous) and the packet in flight is abandoned. No partial packet resumes after reset.
- **All outputs are registered.**

## Structure
- **`nec_uart_pkg`:**
  - `HDR_FRAME`=8'h55, `HDR_REPEAT`=8'h52;
  - `typedef struct packed {logic rpt; logic [7:0] addr; logic [7:0] cmd;} nec_evt_t`;
  - `typedef enum logic [1:0] {IDLE, HDR, ADDR, CMD} tx_state_e`.
- **`nec_evt_fifo`:** one sub-module, a synchronous FIFO of `nec_evt_t` with `FIFO_DEPTH` entries.
  - Pointer width $clog2(FIFO_DEPTH)+1; wrap is detected by the MSB difference.
  - Ports: push, pop, din, dout, full, empty.
  - `nec_uart_ctrl` holds the check logic, context registers, repeat counter, counters and FSM.

## Test plan
- **Single valid frame:** `frame_in`=0x00FFAA55 pulse with `tx_ready`=1 → bytes 0x55, 0x00, 0xAA on consecutive cycles starting at N+2. `frame_err`=0.
- **Repeat after frame:** the frame above, then `repeat_en` → 0x52, 0x00, 0xAA. With `REPEAT_DIV`=3 and 6 repeats, exactly 2 repeat packets and `drop_cnt`=0.
- **Bad frame and orphan repeat:**
  - `frame_in`=0x00FFAA54 → `frame_err` pulse at N+1, no TX bytes.
  - A `repeat_en` after reset with no prior frame → no TX bytes, `drop_cnt`=1.
- **Backpressure and overflow:** `tx_ready`=0; push 6 valid frames with `FIFO_DEPTH`=4. Then raise `tx_ready`.
  - Expect 5 packets (1 in flight + 4 queued) in push order, then `drop_cnt`=1.
  - `tx_data` holds constant while stalled.
- **Simultaneous and random ready:** `frame_en` and `repeat_en` in the same cycle → one 0x55 packet, `drop_cnt`+1. With random `tx_ready`, the byte sequence is unchanged.
- **Reset mid-packet:** assert `sys_rst_n`=0 during the ADDR byte → `tx_valid` drops the same cycle and all counters clear. After release, a `repeat_en` is dropped because `last_ok` has been cleared.
